// File: rtl/char_feeder_if.sv
// Handshake and status bundle between a host, the character feeder and the
// downstream cipher. The host side drives load/go/clear and the cipher drives
// ready_in. The feeder drives the character stream and the status flags.
interface char_feeder_if;
    logic       load;
    logic [4:0] char_in;
    logic       go;
    logic       clear;
    logic       ready_in;
    logic [4:0] char_out;
    logic       char_valid;
    logic [2:0] char_idx;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       err_overflow;
    logic       err_invalid;

    // Host / cipher side
    modport master (
        output load, char_in, go, clear, ready_in,
        input  char_out, char_valid, char_idx, count, busy, done,
               err_overflow, err_invalid
    );

    // Feeder side
    modport slave (
        input  load, char_in, go, clear, ready_in,
        output char_out, char_valid, char_idx, count, busy, done,
               err_overflow, err_invalid
    );
endinterface

// File: rtl/char_feeder.sv
// Character feeder: collects up to eight 5-bit letter codes (0..25) on load
// edges and, on a go edge, streams them in order to a downstream cipher with
// a valid/ready handshake. The buffer and count survive a stream, so a later
// go replays the same message.
module char_feeder (
    input  logic            clk,
    input  logic            reset,
    char_feeder_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [2:0] rd_ptr_q, rd_ptr_d;
    logic       load_prev_q, load_prev_d;
    logic       go_prev_q, go_prev_d;
    logic       err_overflow_q, err_overflow_d;
    logic       err_invalid_q, err_invalid_d;
    logic [4:0] buf_q [8];
    logic [4:0] buf_d [8];

    logic       wr_en;
    logic       load_edge;
    logic       go_edge;
    logic       char_ok;
    logic       is_last;
    logic       valid;

    // Edge detection; the previous-value flops reset to 1 so that a level
    // held high through reset release is not mistaken for a fresh request.
    assign load_edge   = bus.load & ~load_prev_q;
    assign go_edge     = bus.go & ~go_prev_q;
    assign load_prev_d = bus.load;
    assign go_prev_d   = bus.go;

    assign char_ok = (bus.char_in <= 5'd25);
    assign is_last = ({1'b0, rd_ptr_q} == (count_q - 4'd1));

    // Next-state, counters and error pulses
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        rd_ptr_d       = rd_ptr_q;
        wr_en          = 1'b0;
        err_overflow_d = 1'b0;
        err_invalid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear) begin
                    count_d = 4'd0;
                end else if (load_edge) begin
                    // An invalid code is reported even when the buffer is full.
                    if (!char_ok) begin
                        err_invalid_d = 1'b1;
                    end else if (count_q == 4'd8) begin
                        err_overflow_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + 4'd1;
                    end
                end else if (go_edge) begin
                    rd_ptr_d = 3'd0;
                    state_d  = (count_q != 4'd0) ? ST_STREAM : ST_DONE;
                end
            end
            ST_STREAM: begin
                if (bus.clear) begin
                    // Abort: drop the stream without a done pulse.
                    count_d  = 4'd0;
                    rd_ptr_d = 3'd0;
                    state_d  = ST_IDLE;
                end else if (bus.ready_in) begin
                    if (is_last) begin
                        rd_ptr_d = 3'd0;
                        state_d  = ST_DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.clear) begin
                    count_d = 4'd0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            count_q        <= 4'd0;
            rd_ptr_q       <= 3'd0;
            load_prev_q    <= 1'b1;
            go_prev_q      <= 1'b1;
            err_overflow_q <= 1'b0;
            err_invalid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            rd_ptr_q       <= rd_ptr_d;
            load_prev_q    <= load_prev_d;
            go_prev_q      <= go_prev_d;
            err_overflow_q <= err_overflow_d;
            err_invalid_q  <= err_invalid_d;
        end
    end

    // Character buffer: one register per slot, written at index count.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_buf
            // Slot write select
            always_comb begin
                buf_d[gi] = buf_q[gi];
                if (wr_en && (count_q[2:0] == 3'(gi))) begin
                    buf_d[gi] = bus.char_in;
                end
            end

            // Slot register, cleared on reset
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    buf_q[gi] <= 5'd0;
                end else begin
                    buf_q[gi] <= buf_d[gi];
                end
            end
        end
    endgenerate

    // Outputs decode directly from registered state, so reset forces them
    // low immediately and data/index read as zero whenever nothing is valid.
    assign valid            = (state_q == ST_STREAM);
    assign bus.char_valid   = valid;
    assign bus.char_out     = valid ? buf_q[rd_ptr_q] : 5'd0;
    assign bus.char_idx     = valid ? rd_ptr_q : 3'd0;
    assign bus.count        = count_q;
    assign bus.busy         = valid;
    assign bus.done         = (state_q == ST_DONE);
    assign bus.err_overflow = err_overflow_q;
    assign bus.err_invalid  = err_invalid_q;

endmodule

// File: tb/tb_char_feeder.sv
// Directed testbench for char_feeder. Inputs change 1 ns after the rising
// edge and outputs are checked at that point, well away from the next edge.
module tb_char_feeder;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    char_feeder_if bus_if ();

    char_feeder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single clean load pulse; reports the error flags seen after the edge.
    task automatic load_char(input logic [4:0] c, output logic ov, output logic inv);
        bus_if.char_in = c;
        bus_if.load    = 1'b1;
        tick();
        ov  = bus_if.err_overflow;
        inv = bus_if.err_invalid;
        bus_if.load = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        bus_if.clear = 1'b1;
        tick();
        bus_if.clear = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus_if.char_valid, bus_if.char_out, bus_if.char_idx, bus_if.count, bus_if.busy,
             bus_if.done, bus_if.err_overflow, bus_if.err_invalid} !== 17'd0) begin
            $display("FAIL reset_outputs: got v=%b out=%0d idx=%0d cnt=%0d busy=%b done=%b ov=%b inv=%b, need all 0",
                     bus_if.char_valid, bus_if.char_out, bus_if.char_idx, bus_if.count,
                     bus_if.busy, bus_if.done, bus_if.err_overflow, bus_if.err_invalid);
            n_fail++;
        end
        $display("reset: outputs v=%b cnt=%0d", bus_if.char_valid, bus_if.count);
    endtask

    task automatic test_basic_stream();
        logic ov, inv;
        logic [4:0] exp_c [3];
        exp_c[0] = 5'd7; exp_c[1] = 5'd4; exp_c[2] = 5'd11;
        for (int i = 0; i < 3; i++) load_char(exp_c[i], ov, inv);
        n_checks++;
        if (bus_if.count !== 4'd3) begin
            $display("FAIL basic_count: got %0d need 3", bus_if.count); n_fail++;
        end
        // Two passes: the second confirms the message replays unchanged.
        for (int pass = 0; pass < 2; pass++) begin
            bus_if.ready_in = 1'b1;
            bus_if.go = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                bus_if.go = 1'b0;
                n_checks++;
                if (bus_if.char_valid !== 1'b1 || bus_if.char_out !== exp_c[i] ||
                    bus_if.char_idx !== 3'(i) || bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
                    $display("FAIL basic_char%0d_pass%0d: got v=%b out=%0d idx=%0d busy=%b done=%b need v=1 out=%0d idx=%0d busy=1 done=0",
                             i, pass, bus_if.char_valid, bus_if.char_out, bus_if.char_idx,
                             bus_if.busy, bus_if.done, exp_c[i], i);
                    n_fail++;
                end
                $display("stream pass %0d: out=%0d idx=%0d", pass, bus_if.char_out, bus_if.char_idx);
            end
            tick();
            n_checks++;
            if (bus_if.done !== 1'b1 || bus_if.char_valid !== 1'b0 || bus_if.char_out !== 5'd0) begin
                $display("FAIL basic_done_pass%0d: got done=%b v=%b out=%0d need done=1 v=0 out=0",
                         pass, bus_if.done, bus_if.char_valid, bus_if.char_out);
                n_fail++;
            end
            tick();
            n_checks++;
            if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.count !== 4'd3) begin
                $display("FAIL basic_after_pass%0d: got done=%b busy=%b cnt=%0d need done=0 busy=0 cnt=3",
                         pass, bus_if.done, bus_if.busy, bus_if.count);
                n_fail++;
            end
        end
    endtask

    task automatic test_overflow_invalid();
        logic ov, inv;
        do_clear();
        for (int i = 0; i < 8; i++) begin
            load_char(5'(i + 1), ov, inv);
            n_checks++;
            if (ov !== 1'b0 || inv !== 1'b0) begin
                $display("FAIL fill_err%0d: got ov=%b inv=%b need 0 0", i, ov, inv); n_fail++;
            end
        end
        load_char(5'd3, ov, inv);
        $display("ninth load: ov=%b inv=%b cnt=%0d", ov, inv, bus_if.count);
        n_checks++;
        if (ov !== 1'b1 || inv !== 1'b0 || bus_if.count !== 4'd8 || bus_if.err_overflow !== 1'b0) begin
            $display("FAIL overflow: got ov=%b inv=%b cnt=%0d ov_next=%b need ov=1 inv=0 cnt=8 ov_next=0",
                     ov, inv, bus_if.count, bus_if.err_overflow);
            n_fail++;
        end
        load_char(5'd27, ov, inv);
        $display("invalid load on full: ov=%b inv=%b", ov, inv);
        n_checks++;
        if (ov !== 1'b0 || inv !== 1'b1 || bus_if.count !== 4'd8 || bus_if.err_invalid !== 1'b0) begin
            $display("FAIL invalid_full: got ov=%b inv=%b cnt=%0d inv_next=%b need ov=0 inv=1 cnt=8 inv_next=0",
                     ov, inv, bus_if.count, bus_if.err_invalid);
            n_fail++;
        end
        // Stream all eight; slot 7 must still hold 8, not the rejected 3.
        bus_if.ready_in = 1'b1;
        bus_if.go = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus_if.go = 1'b0;
            n_checks++;
            if (bus_if.char_valid !== 1'b1 || bus_if.char_out !== 5'(i + 1) || bus_if.char_idx !== 3'(i)) begin
                $display("FAIL full_char%0d: got v=%b out=%0d idx=%0d need v=1 out=%0d idx=%0d",
                         i, bus_if.char_valid, bus_if.char_out, bus_if.char_idx, i + 1, i);
                n_fail++;
            end
        end
        tick();
        n_checks++;
        if (bus_if.done !== 1'b1) begin
            $display("FAIL full_done: got %b need 1", bus_if.done); n_fail++;
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic ov, inv;
        do_clear();
        load_char(5'd10, ov, inv);
        load_char(5'd20, ov, inv);
        bus_if.ready_in = 1'b0;
        bus_if.go = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus_if.go = 1'b0;
            n_checks++;
            if (bus_if.char_valid !== 1'b1 || bus_if.char_out !== 5'd10 || bus_if.char_idx !== 3'd0) begin
                $display("FAIL stall%0d: got v=%b out=%0d idx=%0d need v=1 out=10 idx=0",
                         i, bus_if.char_valid, bus_if.char_out, bus_if.char_idx);
                n_fail++;
            end
            $display("stall cycle %0d: out=%0d idx=%0d", i, bus_if.char_out, bus_if.char_idx);
        end
        bus_if.ready_in = 1'b1;
        tick();
        n_checks++;
        if (bus_if.char_valid !== 1'b1 || bus_if.char_out !== 5'd20 || bus_if.char_idx !== 3'd1) begin
            $display("FAIL stall_accept: got v=%b out=%0d idx=%0d need v=1 out=20 idx=1",
                     bus_if.char_valid, bus_if.char_out, bus_if.char_idx);
            n_fail++;
        end
        tick();
        n_checks++;
        if (bus_if.done !== 1'b1 || bus_if.char_valid !== 1'b0) begin
            $display("FAIL stall_done: got done=%b v=%b need done=1 v=0", bus_if.done, bus_if.char_valid);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_clear_abort();
        logic ov, inv;
        do_clear();
        load_char(5'd1, ov, inv);
        load_char(5'd2, ov, inv);
        load_char(5'd3, ov, inv);
        bus_if.ready_in = 1'b1;
        bus_if.go = 1'b1;
        tick();
        bus_if.go = 1'b0;
        tick();
        n_checks++;
        if (bus_if.char_idx !== 3'd1 || bus_if.char_out !== 5'd2) begin
            $display("FAIL abort_pre: got idx=%0d out=%0d need idx=1 out=2", bus_if.char_idx, bus_if.char_out);
            n_fail++;
        end
        bus_if.clear = 1'b1;
        tick();
        bus_if.clear = 1'b0;
        $display("clear mid-stream: v=%b cnt=%0d done=%b", bus_if.char_valid, bus_if.count, bus_if.done);
        n_checks++;
        if (bus_if.char_valid !== 1'b0 || bus_if.count !== 4'd0 || bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
            $display("FAIL abort_clear: got v=%b cnt=%0d done=%b busy=%b need 0 0 0 0",
                     bus_if.char_valid, bus_if.count, bus_if.done, bus_if.busy);
            n_fail++;
        end
        tick();
        n_checks++;
        if (bus_if.done !== 1'b0) begin
            $display("FAIL abort_nodone: got done=%b need 0", bus_if.done); n_fail++;
        end
        bus_if.go = 1'b1;
        tick();
        bus_if.go = 1'b0;
        n_checks++;
        if (bus_if.done !== 1'b1 || bus_if.char_valid !== 1'b0) begin
            $display("FAIL empty_go: got done=%b v=%b need done=1 v=0", bus_if.done, bus_if.char_valid);
            n_fail++;
        end
        tick();
        n_checks++;
        if (bus_if.done !== 1'b0 || bus_if.char_valid !== 1'b0) begin
            $display("FAIL empty_go_after: got done=%b v=%b need 0 0", bus_if.done, bus_if.char_valid);
            n_fail++;
        end
    endtask

    task automatic test_load_held_reset();
        bus_if.char_in = 5'd5;
        bus_if.load = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        $display("load held through reset: cnt=%0d", bus_if.count);
        n_checks++;
        if (bus_if.count !== 4'd0) begin
            $display("FAIL held_load: got cnt=%0d need 0", bus_if.count); n_fail++;
        end
        bus_if.load = 1'b0;
        tick();
        bus_if.load = 1'b1;
        tick();
        bus_if.load = 1'b0;
        tick();
        n_checks++;
        if (bus_if.count !== 4'd1) begin
            $display("FAIL repress_load: got cnt=%0d need 1", bus_if.count); n_fail++;
        end
        // Load and go in the same cycle: the load wins and go is dropped.
        bus_if.char_in = 5'd9;
        bus_if.load = 1'b1;
        bus_if.go = 1'b1;
        tick();
        bus_if.load = 1'b0;
        bus_if.go = 1'b0;
        tick();
        n_checks++;
        if (bus_if.count !== 4'd2 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            $display("FAIL load_go_same: got cnt=%0d busy=%b done=%b need 2 0 0",
                     bus_if.count, bus_if.busy, bus_if.done);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        bus_if.ready_in = 1'b0;
        bus_if.go = 1'b1;
        tick();
        bus_if.go = 1'b0;
        n_checks++;
        if (bus_if.char_valid !== 1'b1 || bus_if.char_out !== 5'd5) begin
            $display("FAIL async_pre: got v=%b out=%0d need v=1 out=5", bus_if.char_valid, bus_if.char_out);
            n_fail++;
        end
        #2;
        reset = 1'b1;
        #1;
        $display("async reset mid-stream: v=%b busy=%b cnt=%0d", bus_if.char_valid, bus_if.busy, bus_if.count);
        n_checks++;
        if (bus_if.char_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.count !== 4'd0 ||
            bus_if.char_out !== 5'd0 || bus_if.done !== 1'b0) begin
            $display("FAIL async_reset: got v=%b busy=%b cnt=%0d out=%0d done=%b need all 0",
                     bus_if.char_valid, bus_if.busy, bus_if.count, bus_if.char_out, bus_if.done);
            n_fail++;
        end
        #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.char_valid !== 1'b0) begin
                $display("FAIL async_after%0d: got busy=%b done=%b v=%b need 0 0 0",
                         i, bus_if.busy, bus_if.done, bus_if.char_valid);
                n_fail++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus_if.load     = 1'b0;
        bus_if.char_in  = 5'd0;
        bus_if.go       = 1'b0;
        bus_if.clear    = 1'b0;
        bus_if.ready_in = 1'b0;
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_basic_stream();
        test_overflow_invalid();
        test_backpressure();
        test_clear_abort();
        test_load_held_reset();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/char_feeder.md
CHAR_FEEDER -- requirements
Module: char_feeder

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: load  input  1  level, active-high request to append char_in; rising edge sampled.
REQ-004 SHALL have port: char_in  input  5  character code, 0 ('a') to 25 ('z').
REQ-005 SHALL have port: go  input  1  level, active-high request to start streaming; rising edge sampled.
REQ-006 SHALL have port: clear  input  1  active-high, synchronous buffer empty/abort.
REQ-007 SHALL have port: ready_in  input  1  downstream cipher accepts char_out this cycle.
REQ-008 SHALL have port: char_out  output  5  character presented to the downstream cipher data input.
REQ-009 SHALL have port: char_valid  output  1  char_out is valid.
REQ-010 SHALL have port: char_idx  output  3  buffer index of char_out.
REQ-011 SHALL have port: count  output  4  number of stored characters, 0 to 8.
REQ-012 SHALL have port: busy  output  1  high while in STREAM.
REQ-013 SHALL have port: done  output  1  one-cycle pulse at end of stream.
REQ-014 SHALL have port: err_overflow  output  1  one-cycle pulse when a load is rejected because the buffer is full.
REQ-015 SHALL have port: err_invalid  output  1  one-cycle pulse when a load is rejected because char_in > 25.

Function
REQ-016 SHALL store up to 8 characters of 5 bits each, in load order, at indices 0 to 7.
REQ-017 SHALL detect load and go edges as (current input = 1) AND (previous registered value = 0).
REQ-018 SHALL treat a level held high through reset release as not an edge.
REQ-019 SHALL implement states IDLE, STREAM and DONE.
REQ-020 SHALL, in IDLE on a load edge with char_in ≤ 25 and count < 8, write char_in to buf[count] and increment count on the next edge.
REQ-021 SHALL, in IDLE on a load edge with char_in > 25, leave the buffer unchanged and pulse err_invalid for 1 cycle.
REQ-022 SHALL, in IDLE on a load edge with count = 8 and a valid character, leave the buffer unchanged and pulse err_overflow for 1 cycle.
REQ-023 SHALL, when char_in > 25 and count = 8 together, pulse only err_invalid.
REQ-024 SHALL, in IDLE on a go edge with count > 0, go to STREAM with rd_ptr = 0.
REQ-025 SHALL, in IDLE on a go edge with count = 0, go to DONE without ever asserting char_valid.
REQ-026 SHALL, when load and go edges occur in the same IDLE cycle, process the load and ignore the go.
REQ-027 SHALL, in STREAM, drive char_valid = 1, char_out = buf[rd_ptr] and char_idx = rd_ptr.
REQ-028 SHALL advance rd_ptr only on a cycle where char_valid and ready_in are both high.
REQ-029 SHALL hold char_out stable while ready_in is low.
REQ-030 SHALL, on acceptance of index count−1, go to DONE on the next edge.
REQ-031 SHALL ignore load and go edges while in STREAM.
REQ-032 SHALL ignore load edges while in DONE.
REQ-033 SHALL assert done for exactly 1 cycle while in DONE, then return to IDLE.
REQ-034 SHALL retain buffer contents and count after a stream, so a later go replays the same message.
REQ-035 SHALL, on clear in IDLE, set count to 0.
REQ-036 SHALL, on clear in STREAM, set count to 0, drop char_valid the next cycle, go to IDLE and not pulse done.
REQ-037 SHALL give clear priority over load and go in the same cycle.
REQ-038 SHALL drive char_out = 0 and char_idx = 0 when char_valid = 0.
REQ-039 SHALL have single-state-per-cycle latency: char_valid rises the cycle after the go edge is sampled.

Reset
REQ-040 SHALL, on reset assertion, immediately force state = IDLE, count = 0, rd_ptr = 0, and all outputs to 0.
REQ-041 SHALL, on reset assertion, set the edge-detect registers to 1.
REQ-042 SHALL, on reset assertion, clear buffer contents to 0.
REQ-043 SHALL, on reset asserted mid-STREAM, abort with no done pulse.

Verification
REQ-044 SHALL cover: load 7, 4, 11 (clean edges), ready_in held 1, go → char_valid for 3 consecutive cycles with char_out 7, 4, 11, idx 0, 1, 2; done pulse 1 cycle later; count stays 3.
REQ-045 SHALL cover: 8 valid loads, then a 9th load of 3 → err_overflow = 1 for 1 cycle; count = 8; buf[7] unchanged. Then a load of 27 → only err_invalid pulses.
REQ-046 SHALL cover: streaming 2 chars with ready_in low for 4 cycles on index 0 → char_out held at buf[0]; idx = 0 throughout; acceptance on the first ready_in high cycle.
REQ-047 SHALL cover: clear asserted while streaming index 1 of 3 → char_valid = 0 next cycle; count = 0; no done pulse; a subsequent go → immediate done with no char_valid.
REQ-048 SHALL cover: load held high across reset release → no store; releasing and re-pressing load stores exactly once.
REQ-049 SHALL cover: reset asserted asynchronously between clock edges mid-STREAM → outputs 0 without waiting for a clock edge; state IDLE after release.
